redas_skew_feeder: RTL and testbench
====================================

# redas_skew_feeder

Edge feeder for the roundabout systolic array built from ReDAS processing elements. It accepts one row of LANES operands per valid/ready handshake and drives the array's edge PE inputs with a diagonal skew: lane i sees each row i cycles later than lane 0. After the row marked last it drains the skew pipeline with bubbles and pulses done once the final lane has emitted its last operand.

## Interface
- DATA_WIDTH, 8, operand width; matches PE DATA_WIDTH
- LANES, 4, number of edge PEs fed; legal range 1..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  row offered
- in_ready  output  1  feeder can accept a row this cycle
- in_data  input  LANES*DATA_WIDTH  row; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  input  1  qualifies the final row of a stream
- array_hold  input  1  freeze all skew stages and FSM (array stall)
- edge_data  output  LANES*DATA_WIDTH  skewed operands to edge PE inputs, same lane packing
- edge_valid  output  LANES  per-lane valid
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse: last row leaving lane LANES-1

## Operation
- Accept = in_valid && in_ready; in_ready = !array_hold && state != DRAIN (combinational).
- Lane i is a delay line of i+1 registers; all registers advance together on every cycle with array_hold low.
- Accepting cycle: lane i stage 0 loads in_data lane i, valid 1. Non-accepting, unheld cycle: a bubble enters (valid 0, data per Configuration).
- FSM states IDLE, STREAM, DRAIN:
  - IDLE -> STREAM: accept with in_last = 0.
  - IDLE or STREAM -> DRAIN: accept with in_last = 1 and LANES > 1; drain counter loaded with LANES-1.
  - IDLE or STREAM -> IDLE: accept with in_last = 1 and LANES = 1; done is set.
  - DRAIN: counter decrements on each unheld cycle; when it reaches 0 -> IDLE and done is set.
  - STREAM holds while in_valid = 0 (gaps are legal and produce bubbles).
- done registered, high exactly one cycle, unaffected by array_hold in that cycle.
- Counter width is $clog2(LANES) bits, minimum 1.

## Timing
- Reset: edge_data 0, edge_valid 0, done 0, busy 0, state IDLE, counter 0. in_ready follows !array_hold during reset.
- A row accepted at cycle T appears on lane i in cycle T+1+i, assuming no hold.
- Each held cycle delays every pending output, the drain, and done by exactly one cycle. Outputs are stable while held.
- Last row accepted at T: DRAIN covers cycles T+1..T+LANES-1 with in_ready low. done and edge_valid[LANES-1] for that row are both high in T+LANES. in_ready is high again in T+LANES.
- Back-to-back streams: a new row may be accepted in the same cycle done is high.
- Reset mid-stream or mid-drain clears all stages immediately; no done is issued.

## Configuration
- REDAS_SKEW_ZERO_FILL_EN defined: a bubble stage carries data 0, so the PEs' MACs see 0 operands outside valid rows.
- Undefined: a bubble stage keeps the data of the previous stage-0 value and only clears valid, which saves the data mux. Bench checks of edge_data apply only where edge_valid is high.

## Structure
- Shared package redas_pkg: typedef enum redas_skew_state_e {IDLE, STREAM, DRAIN}. It sits alongside the existing ReDAS enums (roundabout, subarray, role).
- Sub-module redas_skew_delay_line (parameters DATA_WIDTH, DEPTH; ports: shift enable, bubble, data/valid in, data/valid out). It is instantiated once per lane via generate, with DEPTH = i+1.
- Top-level holds the FSM, drain counter, done register and handshake logic.

## Test plan
- Single row, LANES=4: accept 0x04030201 with last at T -> lane0 = 0x01 at T+1, lane1 = 0x02 at T+2, lane2 = 0x03 at T+3, lane3 = 0x04 at T+4. done at T+4. in_ready low T+1..T+3.
- Three back-to-back rows (0x11.., 0x22.., 0x33.. with last) -> each lane shows 3 consecutive valid values, staggered one cycle per lane. done coincides with lane3 = 0x33.
- Gap: row A, idle 2 cycles, row B with last -> two bubbles between A and B on every lane. With ZERO_FILL_EN the bubble data is 0x00.
- array_hold high 3 cycles during DRAIN -> outputs frozen, done delayed by exactly 3 cycles, in_ready stays low.
- rst_n pulsed low mid-DRAIN -> edge_valid 0, busy 0 immediately. No done afterwards. in_ready high after release.
- LANES=1: row 0x5A with last -> edge_data 0x5A and done in T+1. The FSM never enters DRAIN.

Source files
------------

// File: rtl/redas_pkg.sv
// Shared ReDAS package: enums and helpers used by the systolic-array edge logic.
// The skew feeder state enum lives here next to the other ReDAS types.
package redas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } redas_skew_state_e;

    // Drain counter width: enough to hold LANES-1, never narrower than one bit.
    function automatic int skew_cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/redas_skew_delay_line.sv
// One lane of the skew pipeline: DEPTH data/valid registers advancing together.
// REDAS_SKEW_ZERO_FILL_EN: a bubble writes data 0 into stage 0; otherwise the
// stage-0 data is left as-is and only its valid bit is cleared.
module redas_skew_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic                  bubble,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);
    import redas_pkg::*;

    logic [DATA_WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0]      stage_valid;

    // Load stage 0 (row or bubble) and shift the rest down the line when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
            stage_valid <= '0;
        end else if (shift_en) begin
            if (bubble) begin
`ifdef REDAS_SKEW_ZERO_FILL_EN
                stage_data[0] <= '0;
`endif
                stage_valid[0] <= 1'b0;
            end else begin
                stage_data[0]  <= data_in;
                stage_valid[0] <= valid_in;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_data[k]  <= stage_data[k-1];
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    assign data_out  = stage_data[DEPTH-1];
    assign valid_out = stage_valid[DEPTH-1];

endmodule

// File: rtl/redas_skew_feeder.sv
// Diagonal-skew edge feeder for the ReDAS roundabout systolic array.
// Lane i delays each accepted row by i cycles; after the last row the skew
// pipeline drains with bubbles and done pulses as lane LANES-1 emits it.
// Optional build macro: REDAS_SKEW_ZERO_FILL_EN (bubbles carry data 0).
//
// state  | meaning
// IDLE   | no stream in progress, ready for a first row
// STREAM | rows of a stream accepted, waiting for the last row
// DRAIN  | last row accepted, flushing the skew, in_ready low
module redas_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_last,
    input  logic                        array_hold,
    output logic [LANES*DATA_WIDTH-1:0] edge_data,
    output logic [LANES-1:0]            edge_valid,
    output logic                        busy,
    output logic                        done
);
    import redas_pkg::*;

    localparam int CNT_W = skew_cnt_width(LANES);

    redas_skew_state_e state;
    logic [CNT_W-1:0]  drain_cnt;
    logic              accept;
    logic              shift_en;

    assign in_ready = !array_hold && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    assign shift_en = !array_hold;
    assign busy     = (state != IDLE);

    // Stream sequencing, drain down-counter and the one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (!in_last) begin
                            state <= STREAM;
                        end else if (LANES > 1) begin
                            state     <= DRAIN;
                            drain_cnt <= CNT_W'(LANES - 1);
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!array_hold) begin
                        if (drain_cnt == CNT_W'(1)) begin
                            state     <= IDLE;
                            drain_cnt <= '0;
                            done      <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    // One delay line per lane; lane i is i+1 registers deep.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        redas_skew_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_line (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift_en  (shift_en),
            .bubble    (!accept),
            .data_in   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid_in  (1'b1),
            .data_out  (edge_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .valid_out (edge_valid[i])
        );
    end

endmodule

// File: tb/tb_redas_skew_feeder.sv
// Bench for redas_skew_feeder: a LANES=4 instance driven from a cycle table
// with a per-lane scoreboard, plus a LANES=1 instance and hand-written
// sequences for hold, back-to-back streams and reset mid-drain.
module tb_redas_skew_feeder;
    localparam int DW = 8;
    localparam int LN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid, in_last, array_hold, in_ready, busy, done;
    logic [LN*DW-1:0]  in_data, edge_data;
    logic [LN-1:0]     edge_valid;

    logic              one_valid, one_last, one_hold, one_ready, one_busy, one_done;
    logic [DW-1:0]     one_data, one_edata;
    logic [0:0]        one_evalid;

    redas_skew_feeder #(.DATA_WIDTH(DW), .LANES(LN)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .array_hold(array_hold),
        .edge_data(edge_data), .edge_valid(edge_valid), .busy(busy), .done(done)
    );

    redas_skew_feeder #(.DATA_WIDTH(DW), .LANES(1)) u_one (
        .clk(clk), .rst_n(rst_n), .in_valid(one_valid), .in_ready(one_ready),
        .in_data(one_data), .in_last(one_last), .array_hold(one_hold),
        .edge_data(one_edata), .edge_valid(one_evalid), .busy(one_busy), .done(one_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } ent_t;

    typedef struct {
        logic          v;
        logic [LN*DW-1:0] d;
        logic          l;
        logic          h;
        logic          rdy;
    } vec_t;

    ent_t sb [LN][$];
    vec_t tbl [$];

    int errors = 0;
    int checks = 0;
    int eff = 0;
    bit stream_f = 1'b0;
    bit done_pend = 1'b0;
    int done_due = 0;
    logic [LN*DW-1:0] prev_data = '0;
    logic [LN-1:0]    prev_valid = '0;
    logic             prev_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, input logic [LN*DW-1:0] d,
                                input logic l, input logic h, input logic rdy);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.h = h; t.rdy = rdy;
        tbl.push_back(t);
    endfunction

    task automatic sample(input logic held);
        logic ev;
        logic exp_done;
        if (held) begin
            chk("hold_valid", 64'(edge_valid), 64'(prev_valid));
            chk("hold_data", 64'(edge_data), 64'(prev_data));
            chk("hold_done", 64'(done), 64'(0));
            chk("hold_busy", 64'(busy), 64'(prev_busy));
        end else begin
            for (int i = 0; i < LN; i++) begin
                ev = (sb[i].size() > 0) && (sb[i][0].due == eff);
                chk($sformatf("lane%0d_valid", i), 64'(edge_valid[i]), 64'(ev));
                if (ev) begin
                    chk($sformatf("lane%0d_data", i), 64'(edge_data[i*DW +: DW]), 64'(sb[i][0].data));
                    void'(sb[i].pop_front());
                end
`ifdef REDAS_SKEW_ZERO_FILL_EN
                else begin
                    chk($sformatf("lane%0d_bubble", i), 64'(edge_data[i*DW +: DW]), 64'(0));
                end
`endif
            end
            exp_done = done_pend && (eff == done_due);
            chk("done", 64'(done), 64'(exp_done));
            if (exp_done) done_pend = 1'b0;
            chk("busy", 64'(busy), 64'(stream_f || (done_pend && eff < done_due)));
        end
        prev_data  = edge_data;
        prev_valid = edge_valid;
        prev_busy  = busy;
    endtask

    task automatic step(input vec_t t);
        ent_t e;
        in_valid   = t.v;
        in_data    = t.d;
        in_last    = t.l;
        array_hold = t.h;
        #1;
        chk("in_ready", 64'(in_ready), 64'(t.rdy));
        if (!t.h) begin
            if (t.v && t.rdy) begin
                for (int i = 0; i < LN; i++) begin
                    e.data = t.d[i*DW +: DW];
                    e.due  = eff + 1 + i;
                    sb[i].push_back(e);
                end
                if (t.l) begin
                    done_pend = 1'b1;
                    done_due  = eff + LN;
                    stream_f  = 1'b0;
                end else begin
                    stream_f = 1'b1;
                end
            end
            eff++;
        end
        @(posedge clk);
        @(negedge clk);
        sample(t.h);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) add(1'b0, '0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; array_hold = 1'b1;
        one_valid = 1'b0; one_last = 1'b0; one_data = '0; one_hold = 1'b0;

        // hold during IDLE with a row offered: not accepted
        add(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        // single row with last
        add(1'b1, 32'h04030201, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        // three back-to-back rows
        add(1'b1, 32'h14131211, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h24232221, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'h34333231, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        // gap of two cycles inside a stream
        add(1'b1, 32'h44434241, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        add(1'b1, 32'h54535251, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);
        // hold for 3 cycles during DRAIN, then a new stream in the done cycle
        add(1'b1, 32'h64636261, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        add(1'b1, 32'h74737271, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // reset values
        #1;
        chk("rst_ready_held", 64'(in_ready), 64'(0));
        array_hold = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_valid", 64'(edge_valid), 64'(0));
        chk("rst_data", 64'(edge_data), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_one_valid", 64'(one_evalid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LANES=1: row without last, then row with last
        one_valid = 1'b1; one_data = 8'hA5; one_last = 1'b0;
        #1 chk("one_ready0", 64'(one_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        chk("one_valid0", 64'(one_evalid), 64'(1));
        chk("one_data0", 64'(one_edata), 64'(8'hA5));
        chk("one_busy0", 64'(one_busy), 64'(1));
        chk("one_done0", 64'(one_done), 64'(0));
        one_data = 8'h5A; one_last = 1'b1;
        #1 chk("one_ready1", 64'(one_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        one_valid = 1'b0; one_last = 1'b0;
        chk("one_valid1", 64'(one_evalid), 64'(1));
        chk("one_data1", 64'(one_edata), 64'(8'h5A));
        chk("one_done1", 64'(one_done), 64'(1));
        chk("one_busy1", 64'(one_busy), 64'(0));
        #1 chk("one_ready2", 64'(one_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        chk("one_valid2", 64'(one_evalid), 64'(0));
        chk("one_done2", 64'(one_done), 64'(0));

        // table-driven main sequence
        for (int n = 0; n < tbl.size(); n++) step(tbl[n]);

        // reset pulsed mid-drain
        tbl.delete();
        add(1'b1, 32'h84838281, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b0);
        step(tbl[0]);
        step(tbl[1]);
        in_valid = 1'b0; in_last = 1'b0; array_hold = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(edge_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < LN; i++) sb[i].delete();
        done_pend = 1'b0;
        stream_f  = 1'b0;
        prev_data = '0; prev_valid = '0; prev_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tbl.delete();
        idle(6, 1'b1);
        for (int n = 0; n < tbl.size(); n++) step(tbl[n]);

        for (int i = 0; i < LN; i++) begin
            chk($sformatf("lane%0d_leftover", i), 64'(sb[i].size()), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
